// File: rtl/mac_pkg.sv
// Shared definitions for the signed multiply-accumulate datapaths.
// Holds the default MAC geometry and the saturating-add helper that the
// MAC and other accumulators use to clip a sum to a signed output width.
package mac_pkg;

  localparam int DEF_WIDTH     = 10;
  localparam int DEF_OUT_WIDTH = 20;
  localparam int DEF_STAGES    = 5;

  // Operands are handed to sat_add sign-extended to this width, so any
  // accumulator narrower than MAC_MAX_W can share the one helper.
  localparam int MAC_MAX_W = 64;

  typedef struct packed {
    logic [MAC_MAX_W-1:0] sum;  // clipped sum, sign-extended to MAC_MAX_W
    logic                 ovf;  // exact sum fell outside the ow-bit range
  } sat_res_t;

  // Adds two sign-extended values exactly, then clips the result to the
  // signed range of an ow-bit word.
  function automatic sat_res_t sat_add(input logic [MAC_MAX_W-1:0] x,
                                       input logic [MAC_MAX_W-1:0] y,
                                       input int unsigned          ow);
    logic signed [MAC_MAX_W:0] s;
    logic signed [MAC_MAX_W:0] hi;
    logic signed [MAC_MAX_W:0] lo;
    sat_res_t                  res;
    // One guard bit keeps the sum exact for any inputs.
    s  = {x[MAC_MAX_W-1], x} + {y[MAC_MAX_W-1], y};
    hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (ow - 1));
    res.ovf = (s > hi) || (s < lo);
    if (s > hi) begin
      res.sum = hi[MAC_MAX_W-1:0];
    end else if (s < lo) begin
      res.sum = lo[MAC_MAX_W-1:0];
    end else begin
      res.sum = s[MAC_MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Purpose: STAGES-deep signed WIDTH x WIDTH multiplier with a 2-bit sideband.
// Latency: STAGES cycles for product and sideband alike.
// Backpressure: none; advances every cycle.
// Ports: clk/reset (async, active-high); a, b operands; side_in {valid,clear};
//        p product (2*WIDTH, signed); side_out sideband aligned with p.
module mac_mult_pipe #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  input  logic [1:0]                side_in,
  output logic signed [2*WIDTH-1:0] p,
  output logic [1:0]                side_out
);

  logic signed [2*WIDTH-1:0] prod_c;
  logic signed [2*WIDTH-1:0] p_q  [STAGES];
  logic [1:0]                sb_q [STAGES];

  assign prod_c = a * b;

  // The product is formed up front and then carried through the remaining
  // registers, leaving retiming free to spread the multiplier across them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        p_q[i]  <= '0;
        sb_q[i] <= '0;
      end
    end else begin
      p_q[0]  <= prod_c;
      sb_q[0] <= side_in;
      for (int i = 1; i < STAGES; i++) begin
        p_q[i]  <= p_q[i-1];
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  assign p        = p_q[STAGES-1];
  assign side_out = sb_q[STAGES-1];

endmodule

// File: rtl/mac_pipe_sat.sv
// Purpose: pipelined signed MAC with in-band clear, saturate/wrap, sticky overflow.
// Latency: STAGES+1 cycles from the input register edge to f/valid_out.
// Backpressure: none; one sample per cycle in, one valid_out per sample out.
// Ports: clk/reset (async, active-high); valid_in qualifies a, b, clear_in;
//        f accumulator; valid_out one pulse per sample; overflow sticky flag.
module mac_pipe_sat
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int STAGES    = DEF_STAGES,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        clear_in,
  output logic signed [OUT_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        overflow
);

  if (OUT_WIDTH < 2 * WIDTH) begin : g_bad_out_width
    $error("mac_pipe_sat: OUT_WIDTH must be at least 2*WIDTH");
  end
  if (OUT_WIDTH >= MAC_MAX_W) begin : g_bad_out_max
    $error("mac_pipe_sat: OUT_WIDTH must be below MAC_MAX_W");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("mac_pipe_sat: STAGES must be in 1..8");
  end

  // Input registers: operands hold while idle; clear only counts with valid.
  logic signed [WIDTH-1:0] a_q, b_q;
  logic                    vld_q, clr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      vld_q <= valid_in;
      clr_q <= valid_in & clear_in;
      if (valid_in) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  logic signed [2*WIDTH-1:0] prod;
  logic [1:0]                side_m;
  logic                      m_vld, m_clr;

  mac_mult_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .a       (a_q),
    .b       (b_q),
    .side_in ({vld_q, clr_q}),
    .p       (prod),
    .side_out(side_m)
  );

  assign m_vld = side_m[1];
  assign m_clr = side_m[0];

  // Accumulate stage. Both addends are sign-extended to the helper width so
  // the exact sum is available: its low bits give the wrapped result and
  // sat_add gives the clipped result plus the out-of-range flag.
  logic [MAC_MAX_W-1:0]  acc_ext, prod_ext, raw_sum;
  sat_res_t              sat_r;
  logic [OUT_WIDTH-1:0]  next_f;
  logic                  unused_hi_bits;

  assign acc_ext  = m_clr ? '0 : {{(MAC_MAX_W-OUT_WIDTH){f[OUT_WIDTH-1]}}, f};
  assign prod_ext = {{(MAC_MAX_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign raw_sum  = acc_ext + prod_ext;
  assign sat_r    = sat_add(acc_ext, prod_ext, OUT_WIDTH);
  assign next_f   = (SATURATE != 0) ? sat_r.sum[OUT_WIDTH-1:0]
                                    : raw_sum[OUT_WIDTH-1:0];
  assign unused_hi_bits = ^{sat_r.sum[MAC_MAX_W-1:OUT_WIDTH],
                            raw_sum[MAC_MAX_W-1:OUT_WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= m_vld;
      if (m_vld) begin
        f <= next_f;
        // A clear sample restarts the sticky flag from its own result.
        overflow <= m_clr ? sat_r.ovf : (overflow | sat_r.ovf);
      end
    end
  end

endmodule

// File: doc/mac_pipe_sat.md
# mac_pipe_sat

Parametrised pipelined signed multiply-accumulate with an in-band accumulator clear, selectable saturate/wrap accumulation, and a sticky overflow flag. It accepts one operand pair per cycle and has a fixed latency set by the multiplier depth. It is the general MAC used by the filter/dot-product datapaths and replaces fixed-width, fixed-depth, wrap-only MAC instances. Upstream is a valid-qualified sample stream. Downstream consumes `f` on `valid_out`.

## Interface
- `WIDTH`, 10, operand width, signed two's complement
- `OUT_WIDTH`, 20, accumulator/output width; must be >= 2*WIDTH (elaboration-time error otherwise)
- `STAGES`, 5, multiplier pipeline depth in cycles; legal range 1..8
- `SATURATE`, 1, 1 = clip at signed bounds, 0 = wrap modulo 2^OUT_WIDTH

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `valid_in`  in  1  qualifies `a`, `b`, `clear_in`
- `a`  in  WIDTH  signed operand
- `b`  in  WIDTH  signed operand
- `clear_in`  in  1  when high with `valid_in`, this sample starts a new accumulation
- `f`  out  OUT_WIDTH  signed accumulator value
- `valid_out`  out  1  one-cycle pulse per accepted sample, `f` is new
- `overflow`  out  1  sticky; set when an accumulation saturated (SATURATE=1) or wrapped (SATURATE=0)

## Operation
- Reset values: `f`=0, `valid_out`=0, `overflow`=0. All in-flight valid/clear sideband bits are 0.
- Input stage: when `valid_in`=1, register `a`, `b`, and `clear_in`. Sideband valid=`valid_in`. Operand registers hold when `valid_in`=0.
- Multiply: the 2*WIDTH-bit signed product is computed over STAGES registered stages. The valid/clear sideband is delayed by exactly STAGES to stay aligned. The product is sign-extended to OUT_WIDTH+1 bits.
- Accumulate stage, on an aligned valid:
  - clear=1: sum = 0 + product.
  - clear=0: sum = f + product, computed in OUT_WIDTH+1 bits.
- Range check on `sum`, when it falls outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]:
  - SATURATE=1: f <= nearest bound.
  - SATURATE=0: f <= sum[OUT_WIDTH-1:0].
  - In both modes `overflow` <= 1.
- Otherwise f <= sum. `valid_out` pulses with every update.
- `overflow` clearing: it is cleared (set to that sample's overflow result) only by an aligned clear=1 sample. A clear sample cannot itself overflow while OUT_WIDTH >= 2*WIDTH.
- No aligned valid: `f` and `overflow` hold, `valid_out`=0.
- `clear_in` with `valid_in`=0 is ignored.
- No backpressure: every accepted sample produces exactly one `valid_out`. Bubbles of any length are allowed.

## Timing
- Latency: a sample registered at edge k updates `f`/`valid_out` at edge k+STAGES+1. Default: 6 cycles.
- Throughput: 1 sample/cycle. Back-to-back valids give back-to-back `valid_out` pulses, each accumulating the previous `f`. There is no forwarding hazard because the accumulator is a single register.
- Clear mid-stream: a clear sample following non-clear samples affects only its own result and later ones. Earlier in-flight samples accumulate normally.
- `reset` asserted at any time forces the reset values immediately, asynchronously. In-flight samples are discarded, with no `valid_out` for them after release. The first sample after release accumulates onto 0.

## Structure
- Package `mac_pkg`:
  - constants for the default WIDTH/OUT_WIDTH/STAGES
  - function `sat_add`, returning the clipped sum and overflow bit for a given OUT_WIDTH, shared with other accumulators
- Sub-module `mac_mult_pipe`: STAGES-deep signed WIDTH×WIDTH multiplier carrying a 2-bit sideband (valid, clear) with identical delay. The top level holds the input registers and accumulate stage.

## Test plan
- Reset, then a=3,b=4,clear=1 followed by a=-2,b=5 back-to-back:
  - `valid_out` pulses at k+6 and k+7
  - `f`=12 then 2
  - `overflow`=0
- SATURATE=1, three back-to-back samples a=511,b=511 (first with clear):
  - `f`=261121, 522242, then 524287
  - `overflow`=1 from the third result on
- SATURATE=0, same stimulus:
  - third `f`=-265213
  - `overflow`=1
  - a following clear sample a=1,b=1 gives `f`=1, `overflow`=0
- Bubbles: valid samples (2,2,clear), gap 3 cycles, (−512,511):
  - exactly two `valid_out` pulses, 4 cycles apart
  - `f`=4 then −261628
  - `f` holds in the gap
- Reset asserted asynchronously between clock edges with 3 samples in flight:
  - `f`=0, `valid_out`=0, `overflow`=0 immediately
  - no pulses after release
  - next sample a=7,b=−3 gives `f`=−21
- STAGES=1 and STAGES=8 builds, single sample: `valid_out` at k+2 and k+9 respectively.
